alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Execute-stage pipeline controller sitting directly upstream of the 2-bit-command ALU. It accepts decoded register-register operations from decode over a valid/ready handshake and holds them in an EX register. It resolves RAW hazards by forwarding, and translates each operation into ALU operand, carry-in and command signals. It captures the ALU result into a RES register offered to writeback over a second valid/ready handshake.

## Interface
- `XLEN`, default 32: operand and result width; also the ALU `bitWidth`.
- `clk_i`, input, 1: clock; all state updates on rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `flush_i`, input, 1: kill every in-flight operation.
- `in_valid_i`, input, 1: decode offers an operation.
- `in_ready_o`, output, 1: stage accepts the offer this cycle.
- `in_op_i`, input, 3: `exec_op_t` (ADD/SUB/AND/OR/XOR).
- `in_rs1_addr_i` / `in_rs2_addr_i`, input, 5 each: source register indices.
- `in_rs1_data_i` / `in_rs2_data_i`, input, XLEN each: register-file read data.
- `in_rd_i`, input, 5: destination index.
- `in_we_i`, input, 1: operation writes `rd`.
- `alu_rs1_o` / `alu_rs2_o`, output, XLEN each: ALU operands, combinational from the EX register.
- `alu_cin_o`, output, 1: ALU carry-in.
- `alu_cmd_o`, output, 2: ALU command.
- `alu_out_i`, input, XLEN: ALU result, combinational return path.
- `wb_valid_o`, output, 1: RES holds a result.
- `wb_ready_i`, input, 1: writeback consumes.
- `wb_rd_o`, output, 5: destination index.
- `wb_we_o`, output, 1: write enable.
- `wb_data_o`, output, XLEN: result.

## Operation
- Two registered stages: EX (op, forwarded operands, rd, we, valid) and RES (data, rd, we, valid).
- Advance conditions:
  - `res_load = !res_valid || wb_ready_i`.
  - `ex_adv = ex_valid && res_load`.
  - `in_ready_o = !flush_i && (!ex_valid || ex_adv)`.
  - `in_ready_o` is combinationally dependent on `wb_ready_i`; this is intentional, with no skid buffer.
- Accept: `in_valid_i && in_ready_o` loads EX. If nothing is accepted and EX advances, `ex_valid` goes to 0.
- RES load: on `ex_adv`, RES loads `alu_out_i`, EX rd and EX we, and sets `res_valid`. If RES is consumed (`wb_valid_o && wb_ready_i`) without a new load, `res_valid` goes to 0.
- Op translation (EX to ALU):
  - ADD: cmd 00, cin 0.
  - SUB: cmd 00, rs2 bitwise-inverted, cin 1.
  - AND: cmd 01, cin 0.
  - OR: cmd 10, cin 0.
  - XOR: cmd 11, cin 0.
  - Codes 101–111 behave as ADD.
- Arithmetic wraps modulo 2^XLEN; carry-out is discarded.
- Forwarding is resolved per source at accept time, in priority order:
  1. EX hit: `ex_valid && ex_we && ex_rd == src && src != 0` selects `alu_out_i`.
  2. RES hit: `res_valid && res_we && res_rd == src && src != 0` selects RES data.
  3. Otherwise the register-file data is used.
- x0 is never forwarded.
- Writeback-to-regfile bypass is outside this block.
- Flush: `flush_i` clears `ex_valid` and `res_valid` on the next edge and forces `in_ready_o` = 0, so an offer in the same cycle is dropped. Flush overrides every accept, advance and consume.
- Reset: all valids 0; RES data 0, rd 0, we 0. `in_ready_o` is 1 in the first cycle after reset is released. Reset mid-operation discards all in-flight work.

## Timing
- Latency: accepted at edge N; in EX during cycle N+1 (ALU evaluates); `wb_valid_o` asserted in cycle N+2.
- Throughput: one operation per cycle while `wb_ready_i` = 1.
- `wb_*` outputs are registered.
- `alu_*` outputs are combinational from the EX register only. The `alu_out_i` → forward mux → EX register path is the critical path.
- Backpressure: with `wb_ready_i` = 0, RES holds stable, EX holds once full, and `in_ready_o` falls in the same cycle.
- Simultaneous consume and load of RES: RES loads the new result and `wb_valid_o` stays 1.

## Structure
- Package `exec_pkg`:
  - `exec_op_t` enum: ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, XOR=3'b100.
  - ALU command constants: `ALU_ADD`=2'b00, `ALU_AND`=2'b01, `ALU_OR`=2'b10, `ALU_XOR`=2'b11.
  - EX and RES struct typedefs.
- One sub-module, `operand_fwd`: a single-source forward comparator/mux, instantiated twice (rs1, rs2).
- The ALU is instantiated beside this block in the core top, not inside it.

## Test plan
- Reset, then ADD x3=x1+x2 with data 5, 7 and `wb_ready_i`=1 → `wb_valid_o` in cycle N+2 with rd=3, data=12, we=1.
- SUB 3−5 → `alu_rs2_o`=0xFFFFFFFA, cin=1, cmd=00; `wb_data_o`=0xFFFFFFFE. ADD 0xFFFFFFFF+1 → 0.
- Back-to-back forwarding:
  - ADD x5=1+2, then XOR x6=x5^x5 with stale regfile data 0xDEAD → result 0 (EX forward).
  - A third op using x5 one cycle later takes the RES forward value 3.
  - An op targeting x0 followed by a read of x0 → regfile data used.
- Backpressure: `wb_ready_i`=0 for 4 cycles with 3 ops offered → RES and EX hold, `in_ready_o`=0 after the second accept. Release → results emerge in order with no loss or duplication.
- Flush with both stages full plus an offer → next cycle `wb_valid_o`=0, the offer is not accepted, and a new op issued afterward completes normally.
- `rst_i` asserted with both stages full → next cycle `wb_valid_o`=0, `wb_data_o`=0, `in_ready_o`=1 after release.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the ALU execute stage: operation codes, ALU commands
// and the control payloads carried by the EX and RES pipeline registers.
package exec_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CMD_W = 2;
    localparam int unsigned REG_W = 5;

    typedef enum logic [OP_W-1:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100
    } exec_op_t;

    localparam logic [CMD_W-1:0] ALU_ADD = 2'b00;
    localparam logic [CMD_W-1:0] ALU_AND = 2'b01;
    localparam logic [CMD_W-1:0] ALU_OR  = 2'b10;
    localparam logic [CMD_W-1:0] ALU_XOR = 2'b11;

    // Operand data lives beside these structs so XLEN can stay a module parameter.
    typedef struct packed {
        exec_op_t         op;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             valid;
    } ex_ctrl_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             we;
        logic             valid;
    } res_ctrl_t;

endpackage

// File: rtl/operand_fwd.sv
// Single-source forwarding mux: EX result beats RES data beats register file;
// x0 is never forwarded.
module operand_fwd
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [XLEN-1:0]  rf_data_i,
    input  logic             ex_valid_i,
    input  logic             ex_we_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic [XLEN-1:0]  ex_data_i,
    input  logic             res_valid_i,
    input  logic             res_we_i,
    input  logic [REG_W-1:0] res_rd_i,
    input  logic [XLEN-1:0]  res_data_i,
    output logic [XLEN-1:0]  fwd_data_c
);

    logic src_nz;
    logic ex_hit;
    logic res_hit;

    always_comb begin
        src_nz  = (src_i != '0);
        ex_hit  = ex_valid_i && ex_we_i && (ex_rd_i == src_i) && src_nz;
        res_hit = res_valid_i && res_we_i && (res_rd_i == src_i) && src_nz;
        fwd_data_c = rf_data_i;
        if (ex_hit) begin
            fwd_data_c = ex_data_i;
        end else if (res_hit) begin
            fwd_data_c = res_data_i;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage controller: EX register with operand forwarding feeding an
// external ALU, and a RES register handing results to writeback.
module alu_exec_stage
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [OP_W-1:0]   in_op_i,
    input  logic [REG_W-1:0]  in_rs1_addr_i,
    input  logic [REG_W-1:0]  in_rs2_addr_i,
    input  logic [XLEN-1:0]   in_rs1_data_i,
    input  logic [XLEN-1:0]   in_rs2_data_i,
    input  logic [REG_W-1:0]  in_rd_i,
    input  logic              in_we_i,
    output logic [XLEN-1:0]   alu_rs1_o,
    output logic [XLEN-1:0]   alu_rs2_o,
    output logic              alu_cin_o,
    output logic [CMD_W-1:0]  alu_cmd_o,
    input  logic [XLEN-1:0]   alu_out_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [REG_W-1:0]  wb_rd_o,
    output logic              wb_we_o,
    output logic [XLEN-1:0]   wb_data_o
);

    ex_ctrl_t        ex_ctrl_q,  ex_ctrl_d;
    logic [XLEN-1:0] ex_rs1_q,   ex_rs1_d;
    logic [XLEN-1:0] ex_rs2_q,   ex_rs2_d;
    res_ctrl_t       res_ctrl_q, res_ctrl_d;
    logic [XLEN-1:0] res_data_q, res_data_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            res_load;
    logic            ex_adv;
    logic            res_upd;
    logic            accept;

    // No skid buffer: in_ready_o sees wb_ready_i through res_load.
    always_comb begin
        res_load   = !res_ctrl_q.valid || wb_ready_i;
        ex_adv     = ex_ctrl_q.valid && res_load;
        res_upd    = ex_adv && !flush_i;
        in_ready_o = !flush_i && (!ex_ctrl_q.valid || ex_adv);
        accept     = in_valid_i && in_ready_o;
    end

    operand_fwd #(.XLEN(XLEN)) u_fwd_rs1 (
        .src_i       (in_rs1_addr_i),
        .rf_data_i   (in_rs1_data_i),
        .ex_valid_i  (ex_ctrl_q.valid),
        .ex_we_i     (ex_ctrl_q.we),
        .ex_rd_i     (ex_ctrl_q.rd),
        .ex_data_i   (alu_out_i),
        .res_valid_i (res_ctrl_q.valid),
        .res_we_i    (res_ctrl_q.we),
        .res_rd_i    (res_ctrl_q.rd),
        .res_data_i  (res_data_q),
        .fwd_data_c  (fwd_rs1)
    );

    operand_fwd #(.XLEN(XLEN)) u_fwd_rs2 (
        .src_i       (in_rs2_addr_i),
        .rf_data_i   (in_rs2_data_i),
        .ex_valid_i  (ex_ctrl_q.valid),
        .ex_we_i     (ex_ctrl_q.we),
        .ex_rd_i     (ex_ctrl_q.rd),
        .ex_data_i   (alu_out_i),
        .res_valid_i (res_ctrl_q.valid),
        .res_we_i    (res_ctrl_q.we),
        .res_rd_i    (res_ctrl_q.rd),
        .res_data_i  (res_data_q),
        .fwd_data_c  (fwd_rs2)
    );

    // Pipeline next state; flush wins over accept, advance and consume.
    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        res_ctrl_d = res_ctrl_q;
        res_data_d = res_data_q;

        if (accept) begin
            ex_ctrl_d.op    = exec_op_t'(in_op_i);
            ex_ctrl_d.rd    = in_rd_i;
            ex_ctrl_d.we    = in_we_i;
            ex_ctrl_d.valid = 1'b1;
            ex_rs1_d        = fwd_rs1;
            ex_rs2_d        = fwd_rs2;
        end else if (ex_adv) begin
            ex_ctrl_d.valid = 1'b0;
        end

        if (res_upd) begin
            res_data_d       = alu_out_i;
            res_ctrl_d.rd    = ex_ctrl_q.rd;
            res_ctrl_d.we    = ex_ctrl_q.we;
            res_ctrl_d.valid = 1'b1;
        end else if (res_ctrl_q.valid && wb_ready_i) begin
            res_ctrl_d.valid = 1'b0;
        end

        if (flush_i) begin
            ex_ctrl_d.valid  = 1'b0;
            res_ctrl_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_ctrl_q  <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            res_ctrl_q <= '0;
            res_data_q <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            res_ctrl_q <= res_ctrl_d;
            res_data_q <= res_data_d;
        end
    end

    // SUB is rs1 + ~rs2 + 1 on the adder; undefined op codes fall back to ADD.
    always_comb begin
        alu_rs1_o = ex_rs1_q;
        alu_rs2_o = ex_rs2_q;
        alu_cin_o = 1'b0;
        alu_cmd_o = ALU_ADD;
        case (ex_ctrl_q.op)
            SUB: begin
                alu_rs2_o = ~ex_rs2_q;
                alu_cin_o = 1'b1;
            end
            AND:     alu_cmd_o = ALU_AND;
            OR:      alu_cmd_o = ALU_OR;
            XOR:     alu_cmd_o = ALU_XOR;
            default: alu_cmd_o = ALU_ADD;
        endcase
    end

    assign wb_valid_o = res_ctrl_q.valid;
    assign wb_rd_o    = res_ctrl_q.rd;
    assign wb_we_o    = res_ctrl_q.we;
    assign wb_data_o  = res_data_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: a behavioural ALU beside the DUT, and an in-flight
// queue model that predicts handshakes, forwarding and writeback results.
module tb_alu_exec_stage;

    localparam int unsigned XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2:0]      in_op_i;
    logic [4:0]      in_rs1_addr_i;
    logic [4:0]      in_rs2_addr_i;
    logic [XLEN-1:0] in_rs1_data_i;
    logic [XLEN-1:0] in_rs2_data_i;
    logic [4:0]      in_rd_i;
    logic            in_we_i;
    logic [XLEN-1:0] alu_rs1_o;
    logic [XLEN-1:0] alu_rs2_o;
    logic            alu_cin_o;
    logic [1:0]      alu_cmd_o;
    logic [XLEN-1:0] alu_out_i;
    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [4:0]      wb_rd_o;
    logic            wb_we_o;
    logic [XLEN-1:0] wb_data_o;

    always #5 clk_i = ~clk_i;

    alu_exec_stage #(.XLEN(XLEN)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_op_i       (in_op_i),
        .in_rs1_addr_i (in_rs1_addr_i),
        .in_rs2_addr_i (in_rs2_addr_i),
        .in_rs1_data_i (in_rs1_data_i),
        .in_rs2_data_i (in_rs2_data_i),
        .in_rd_i       (in_rd_i),
        .in_we_i       (in_we_i),
        .alu_rs1_o     (alu_rs1_o),
        .alu_rs2_o     (alu_rs2_o),
        .alu_cin_o     (alu_cin_o),
        .alu_cmd_o     (alu_cmd_o),
        .alu_out_i     (alu_out_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_rd_o       (wb_rd_o),
        .wb_we_o       (wb_we_o),
        .wb_data_o     (wb_data_o)
    );

    // The 2-bit-command ALU that sits beside the stage in the core.
    always_comb begin
        case (alu_cmd_o)
            2'b01:   alu_out_i = alu_rs1_o & alu_rs2_o;
            2'b10:   alu_out_i = alu_rs1_o | alu_rs2_o;
            2'b11:   alu_out_i = alu_rs1_o ^ alu_rs2_o;
            default: alu_out_i = alu_rs1_o + alu_rs2_o + XLEN'(alu_cin_o);
        endcase
    end

    typedef struct {
        bit          v;
        logic [2:0]  op;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        bit          we;
        bit          wbr;
        bit          fl;
    } stim_t;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] res;
        bit          in_res;
    } item_t;

    item_t q[$];
    int    vectors = 0;
    int    miscompares = 0;

    logic        obs_ready, obs_wbv, obs_we, obs_cin;
    logic [4:0]  obs_rd;
    logic [1:0]  obs_cmd;
    logic [31:0] obs_data, obs_rs2;
    logic        exp_ready, exp_wbv;
    logic [37:0] exp_wb;

    function automatic stim_t mk(int v, int op, int s1, int s2, logic [31:0] d1,
                                 logic [31:0] d2, int rd, int we, int wbr, int fl);
        stim_t s;
        s.v = (v != 0);
        s.op = 3'(op);
        s.s1 = 5'(s1);
        s.s2 = 5'(s2);
        s.d1 = d1;
        s.d2 = d2;
        s.rd = 5'(rd);
        s.we = (we != 0);
        s.wbr = (wbr != 0);
        s.fl = (fl != 0);
        return s;
    endfunction

    function automatic stim_t idle(int wbr);
        return mk(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, wbr, 0);
    endfunction

    function automatic logic [31:0] op_result(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Newest in-flight writer of a non-zero register supplies the operand.
    function automatic logic [31:0] model_operand(logic [4:0] src, logic [31:0] rf);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].we && q[i].rd == src && src != 5'd0) return q[i].res;
        end
        return rf;
    endfunction

    // Apply one cycle of stimulus, sample DUT and model, then step past the edge.
    task automatic tick(input stim_t s);
        item_t       it;
        logic [31:0] a;
        logic [31:0] b;
        bit          acc;
        in_valid_i    = s.v;
        in_op_i       = s.op;
        in_rs1_addr_i = s.s1;
        in_rs2_addr_i = s.s2;
        in_rs1_data_i = s.d1;
        in_rs2_data_i = s.d2;
        in_rd_i       = s.rd;
        in_we_i       = s.we;
        wb_ready_i    = s.wbr;
        flush_i       = s.fl;
        #5;
        obs_ready = in_ready_o;
        obs_wbv   = wb_valid_o;
        obs_rd    = wb_rd_o;
        obs_we    = wb_we_o;
        obs_data  = wb_data_o;
        obs_rs2   = alu_rs2_o;
        obs_cin   = alu_cin_o;
        obs_cmd   = alu_cmd_o;
        exp_ready = !s.fl && (q.size() < 2 || s.wbr);
        exp_wbv   = (q.size() > 0) && q[0].in_res;
        exp_wb    = exp_wbv ? {q[0].rd, q[0].we, q[0].res} : 38'h0;
        acc       = s.v && exp_ready;
        a = model_operand(s.s1, s.d1);
        b = model_operand(s.s2, s.d2);
        if (s.fl) begin
            q.delete();
        end else begin
            if (exp_wbv && s.wbr) void'(q.pop_front());
            if (q.size() == 1 && !q[0].in_res) q[0].in_res = 1'b1;
            if (acc) begin
                it.rd = s.rd;
                it.we = s.we;
                it.res = op_result(s.op, a, b);
                it.in_res = 1'b0;
                q.push_back(it);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset(input string tag);
        rst_i = 1'b1;
        in_valid_i = 1'b1;
        wb_ready_i = 1'b0;
        flush_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        q.delete();
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        #4;
        vectors++;
        if (wb_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s wb_valid_o: got %b exp 0", tag, wb_valid_o);
        end
        vectors++;
        if (wb_data_o !== 32'h0 || wb_rd_o !== 5'd0 || wb_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s wb fields: got rd=%0d we=%b data=%h exp 0", tag, wb_rd_o, wb_we_o, wb_data_o);
        end
        vectors++;
        if (in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s in_ready_o: got %b exp 1", tag, in_ready_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_add();
        stim_t s[3];
        s[0] = mk(1, 0, 1, 2, 32'd5, 32'd7, 3, 1, 1, 0);
        s[1] = idle(1);
        s[2] = idle(1);
        for (int i = 0; i < 3; i++) begin
            tick(s[i]);
            vectors++;
            if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL add in_ready c%0d: got %b exp %b", i, obs_ready, exp_ready); end
            vectors++;
            if (obs_wbv !== exp_wbv) begin miscompares++; $display("FAIL add wb_valid c%0d: got %b exp %b", i, obs_wbv, exp_wbv); end
            if (exp_wbv) begin
                vectors++;
                if ({obs_rd, obs_we, obs_data} !== exp_wb) begin miscompares++; $display("FAIL add wb c%0d: got %h exp %h", i, {obs_rd, obs_we, obs_data}, exp_wb); end
            end
            if (i == 2) begin
                vectors++;
                if (obs_wbv !== 1'b1 || obs_rd !== 5'd3 || obs_we !== 1'b1 || obs_data !== 32'd12) begin
                    miscompares++;
                    $display("FAIL add latency: got v=%b rd=%0d we=%b data=%0d exp v=1 rd=3 we=1 data=12", obs_wbv, obs_rd, obs_we, obs_data);
                end
            end
        end
    endtask

    task automatic test_sub_wrap();
        stim_t s[4];
        s[0] = mk(1, 1, 1, 2, 32'd3, 32'd5, 4, 1, 1, 0);
        s[1] = mk(1, 0, 10, 11, 32'hFFFF_FFFF, 32'd1, 9, 1, 1, 0);
        s[2] = idle(1);
        s[3] = idle(1);
        for (int i = 0; i < 4; i++) begin
            tick(s[i]);
            vectors++;
            if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL sub in_ready c%0d: got %b exp %b", i, obs_ready, exp_ready); end
            vectors++;
            if (obs_wbv !== exp_wbv) begin miscompares++; $display("FAIL sub wb_valid c%0d: got %b exp %b", i, obs_wbv, exp_wbv); end
            if (exp_wbv) begin
                vectors++;
                if ({obs_rd, obs_we, obs_data} !== exp_wb) begin miscompares++; $display("FAIL sub wb c%0d: got %h exp %h", i, {obs_rd, obs_we, obs_data}, exp_wb); end
            end
            if (i == 1) begin
                vectors++;
                if (obs_rs2 !== 32'hFFFF_FFFA || obs_cin !== 1'b1 || obs_cmd !== 2'b00) begin
                    miscompares++;
                    $display("FAIL sub alu drive: got rs2=%h cin=%b cmd=%b exp rs2=fffffffa cin=1 cmd=00", obs_rs2, obs_cin, obs_cmd);
                end
            end
            if (i == 2) begin
                vectors++;
                if (obs_data !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sub result: got %h exp fffffffe", obs_data); end
            end
            if (i == 3) begin
                vectors++;
                if (obs_data !== 32'h0 || obs_rd !== 5'd9) begin miscompares++; $display("FAIL add wrap: got rd=%0d data=%h exp rd=9 data=0", obs_rd, obs_data); end
            end
        end
    endtask

    task automatic test_forwarding();
        stim_t s[8];
        s[0] = mk(1, 0, 1, 2, 32'd1, 32'd2, 5, 1, 1, 0);
        s[1] = mk(1, 4, 5, 5, 32'hDEAD, 32'hDEAD, 6, 1, 1, 0);
        s[2] = mk(1, 0, 5, 0, 32'hDEAD, 32'd10, 7, 1, 1, 0);
        s[3] = mk(1, 0, 1, 1, 32'd4, 32'd4, 0, 1, 1, 0);
        s[4] = mk(1, 0, 0, 0, 32'd6, 32'd6, 8, 1, 1, 0);
        s[5] = idle(1);
        s[6] = idle(1);
        s[7] = idle(1);
        for (int i = 0; i < 8; i++) begin
            tick(s[i]);
            vectors++;
            if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL fwd in_ready c%0d: got %b exp %b", i, obs_ready, exp_ready); end
            vectors++;
            if (obs_wbv !== exp_wbv) begin miscompares++; $display("FAIL fwd wb_valid c%0d: got %b exp %b", i, obs_wbv, exp_wbv); end
            if (exp_wbv) begin
                vectors++;
                if ({obs_rd, obs_we, obs_data} !== exp_wb) begin miscompares++; $display("FAIL fwd wb c%0d: got %h exp %h", i, {obs_rd, obs_we, obs_data}, exp_wb); end
            end
            if (i == 3) begin
                vectors++;
                if (obs_rd !== 5'd6 || obs_data !== 32'h0) begin miscompares++; $display("FAIL fwd ex hit: got rd=%0d data=%h exp rd=6 data=0", obs_rd, obs_data); end
            end
            if (i == 4) begin
                vectors++;
                if (obs_rd !== 5'd7 || obs_data !== 32'd13) begin miscompares++; $display("FAIL fwd res hit: got rd=%0d data=%0d exp rd=7 data=13", obs_rd, obs_data); end
            end
            if (i == 6) begin
                vectors++;
                if (obs_rd !== 5'd8 || obs_data !== 32'd12) begin miscompares++; $display("FAIL fwd x0: got rd=%0d data=%0d exp rd=8 data=12", obs_rd, obs_data); end
            end
        end
    endtask

    task automatic test_backpressure();
        stim_t s[8];
        s[0] = mk(1, 0, 20, 21, 32'd100, 32'd1, 11, 1, 0, 0);
        s[1] = mk(1, 0, 20, 21, 32'd200, 32'd2, 12, 1, 0, 0);
        s[2] = mk(1, 0, 20, 21, 32'd300, 32'd3, 13, 1, 0, 0);
        s[3] = mk(1, 0, 20, 21, 32'd300, 32'd3, 13, 1, 0, 0);
        s[4] = mk(1, 0, 20, 21, 32'd300, 32'd3, 13, 1, 1, 0);
        s[5] = idle(1);
        s[6] = idle(1);
        s[7] = idle(1);
        for (int i = 0; i < 8; i++) begin
            tick(s[i]);
            vectors++;
            if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL bp in_ready c%0d: got %b exp %b", i, obs_ready, exp_ready); end
            vectors++;
            if (obs_wbv !== exp_wbv) begin miscompares++; $display("FAIL bp wb_valid c%0d: got %b exp %b", i, obs_wbv, exp_wbv); end
            if (exp_wbv) begin
                vectors++;
                if ({obs_rd, obs_we, obs_data} !== exp_wb) begin miscompares++; $display("FAIL bp wb c%0d: got %h exp %h", i, {obs_rd, obs_we, obs_data}, exp_wb); end
            end
            if (i == 2 || i == 3) begin
                vectors++;
                if (obs_ready !== 1'b0 || obs_data !== 32'd101 || obs_rd !== 5'd11) begin
                    miscompares++;
                    $display("FAIL bp hold c%0d: got ready=%b rd=%0d data=%0d exp ready=0 rd=11 data=101", i, obs_ready, obs_rd, obs_data);
                end
            end
            if (i == 6) begin
                vectors++;
                if (obs_rd !== 5'd13 || obs_data !== 32'd303) begin miscompares++; $display("FAIL bp last: got rd=%0d data=%0d exp rd=13 data=303", obs_rd, obs_data); end
            end
        end
    endtask

    task automatic test_flush();
        stim_t s[6];
        s[0] = mk(1, 2, 22, 23, 32'hF0F0, 32'h0FF0, 14, 1, 0, 0);
        s[1] = mk(1, 3, 22, 23, 32'hF0F0, 32'h0F0F, 15, 1, 0, 0);
        s[2] = mk(1, 0, 22, 23, 32'd1, 32'd1, 16, 1, 1, 1);
        s[3] = mk(1, 0, 14, 15, 32'd40, 32'd2, 17, 1, 1, 0);
        s[4] = idle(1);
        s[5] = idle(1);
        for (int i = 0; i < 6; i++) begin
            tick(s[i]);
            vectors++;
            if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL flush in_ready c%0d: got %b exp %b", i, obs_ready, exp_ready); end
            vectors++;
            if (obs_wbv !== exp_wbv) begin miscompares++; $display("FAIL flush wb_valid c%0d: got %b exp %b", i, obs_wbv, exp_wbv); end
            if (exp_wbv) begin
                vectors++;
                if ({obs_rd, obs_we, obs_data} !== exp_wb) begin miscompares++; $display("FAIL flush wb c%0d: got %h exp %h", i, {obs_rd, obs_we, obs_data}, exp_wb); end
            end
            if (i == 2) begin
                vectors++;
                if (obs_ready !== 1'b0) begin miscompares++; $display("FAIL flush ready: got %b exp 0", obs_ready); end
            end
            if (i == 3 || i == 4) begin
                vectors++;
                if (obs_wbv !== 1'b0) begin miscompares++; $display("FAIL flush kill c%0d: got wb_valid %b exp 0", i, obs_wbv); end
            end
            if (i == 5) begin
                vectors++;
                if (obs_wbv !== 1'b1 || obs_rd !== 5'd17 || obs_data !== 32'd42) begin
                    miscompares++;
                    $display("FAIL flush restart: got v=%b rd=%0d data=%0d exp v=1 rd=17 data=42", obs_wbv, obs_rd, obs_data);
                end
            end
        end
    endtask

    task automatic test_fill();
        tick(mk(1, 0, 24, 25, 32'd9, 32'd9, 18, 1, 0, 0));
        tick(mk(1, 0, 24, 25, 32'd8, 32'd8, 19, 1, 0, 0));
        vectors++;
        if (wb_valid_o !== 1'b1) begin miscompares++; $display("FAIL fill wb_valid: got %b exp 1", wb_valid_o); end
    endtask

    task automatic test_random();
        stim_t s;
        for (int i = 0; i < 600; i++) begin
            s = mk(($urandom % 4) != 0 ? 1 : 0, int'($urandom % 8), int'($urandom % 4), int'($urandom % 4),
                   $urandom, ($urandom % 3 == 0) ? 32'hFFFF_FFFF : $urandom, int'($urandom % 4),
                   ($urandom % 4) != 0 ? 1 : 0, ($urandom % 3) != 0 ? 1 : 0, ($urandom % 40) == 0 ? 1 : 0);
            tick(s);
            vectors++;
            if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL rnd in_ready c%0d: got %b exp %b", i, obs_ready, exp_ready); end
            vectors++;
            if (obs_wbv !== exp_wbv) begin miscompares++; $display("FAIL rnd wb_valid c%0d: got %b exp %b", i, obs_wbv, exp_wbv); end
            if (exp_wbv) begin
                vectors++;
                if ({obs_rd, obs_we, obs_data} !== exp_wb) begin miscompares++; $display("FAIL rnd wb c%0d: got %h exp %h", i, {obs_rd, obs_we, obs_data}, exp_wb); end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        in_op_i = 3'd0;
        in_rs1_addr_i = 5'd0;
        in_rs2_addr_i = 5'd0;
        in_rs1_data_i = 32'h0;
        in_rs2_data_i = 32'h0;
        in_rd_i = 5'd0;
        in_we_i = 1'b0;
        wb_ready_i = 1'b0;
        #1;
        test_reset("reset");
        test_add();
        test_sub_wrap();
        test_forwarding();
        test_backpressure();
        test_flush();
        test_fill();
        test_reset("reset_midop");
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
